// File: rtl/y86_mem_scheduler.sv
// Shares the y86 core memory bus with a block-transfer engine; the core always wins,
// the engine moves one word per otherwise idle bus cycle.
module y86_mem_scheduler #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic             cpu_re,
  input  logic             cpu_we,
  output logic [31:0]      cpu_rdata,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             done,
  output logic             busy,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [31:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic             dir;
  logic             cpu_busy;
  logic             grant;

  assign cpu_busy = cpu_re | cpu_we;
  // A read grant needs a free output slot, either empty or being drained this cycle.
  assign grant    = (state == RUN) & ~cpu_busy &
                    (dir ? wr_valid : (~rd_valid | rd_ready));

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (cpu_busy) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_re    = cpu_re;
      mem_we    = cpu_we;
    end else if (grant) begin
      mem_addr  = addr;
      mem_wdata = wr_data;
      mem_re    = ~dir;
      mem_we    = dir;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign wr_ready  = grant & dir;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            dir       <= cmd_write;
            state     <= (cmd_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (grant) begin
            addr      <= addr + 32'(ADDR_STEP);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A reload in the same cycle as a consume keeps the slot full with the new word.
      if (grant && !dir) begin
        rd_data  <= mem_rdata;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule
